// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus stage.
//   bus_state_e : bus sequencer state (RUN = launching accesses, WAIT = window stall)
//   win_match() : address window compare, operands zero-extended to MAX_AW bits
package cpu_bus_pkg;

    localparam int MAX_AW = 64;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } bus_state_e;

    function automatic logic win_match(
        input logic [MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/cpu_bus_stage_sync_chain.sv
// Multi-flop synchroniser for an asynchronous active-low level.
//   clk   : destination clock
//   reset : synchronous, active-high; chain resets to all 1s (deasserted)
//   d     : asynchronous input
//   q     : synchronised output, STAGES clk edges after d changes
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_bus_stage.sv
// Bus stage between a 6502-class core and the system bus.
//   core_ce            : core clock enable, one clk every CE_DIV clks
//   core_ab/dbo/we     : core address, write data, write enable (sampled on core_ce)
//   ab/dbo/we_n        : registered bus address, write data, active-low write strobe
//   bus_stb            : one-clk pulse when a new bus cycle is launched
//   core_rdy           : low stalls the core (wait window or ext_ready low)
//   ext_ready          : external ready, sampled on core_ce clks only
//   irq_n_in/nmi_n_in  : asynchronous interrupts; irq_n/nmi_n are synchronised copies
module cpu_bus_stage
    import cpu_bus_pkg::*;
#(
    parameter int          AW          = 16,
    parameter int          DW          = 8,
    parameter int          CE_DIV      = 4,
    parameter logic [AW-1:0] WAIT_BASE = 'h8000,
    parameter logic [AW-1:0] WAIT_MASK = 'hC000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] core_ab,
    input  logic [DW-1:0] core_dbo,
    input  logic          core_we,
    output logic          core_ce,
    output logic          core_rdy,
    output logic [AW-1:0] ab,
    output logic [DW-1:0] dbo,
    output logic          we_n,
    output logic          bus_stb,
    input  logic          ext_ready,
    input  logic          irq_n_in,
    input  logic          nmi_n_in,
    output logic          irq_n,
    output logic          nmi_n
);

    localparam int              CNT_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int              WC_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);
    localparam logic [WC_W-1:0]  WC_INIT  = WC_W'(WAIT_CYCLES);
    localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
    localparam logic             WIN_EN   = (WAIT_CYCLES > 0);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WC_W-1:0]  wcnt_q,     wcnt_d;
    bus_state_e       state_q,    state_d;
    logic [AW-1:0]    ab_q,       ab_d;
    logic [DW-1:0]    dbo_q,      dbo_d;
    logic             we_n_q,     we_n_d;
    logic             bus_stb_q,  bus_stb_d;
    logic             core_rdy_q, core_rdy_d;
    logic             in_window;

    // With CE_DIV=1 the counter is pinned at 0 == CNT_LAST, so core_ce is constant 1.
    assign core_ce   = (cnt_q == CNT_LAST);
    assign in_window = WIN_EN && win_match(MAX_AW'(core_ab), MAX_AW'(WAIT_BASE), MAX_AW'(WAIT_MASK));

    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        wcnt_d     = wcnt_q;
        state_d    = state_q;
        ab_d       = ab_q;
        dbo_d      = dbo_q;
        we_n_d     = we_n_q;
        bus_stb_d  = 1'b0;
        core_rdy_d = core_rdy_q;

        if (core_ce) begin
            if (state_q == RUN) begin
                ab_d      = core_ab;
                dbo_d     = core_dbo;
                we_n_d    = ~core_we;
                bus_stb_d = 1'b1;
                if (in_window) begin
                    state_d    = WAIT;
                    wcnt_d     = WC_INIT;
                    core_rdy_d = 1'b0;
                end else begin
                    core_rdy_d = ext_ready;
                end
            end else begin
                // ext_ready only matters on the final window period; before that it is ignored.
                if (wcnt_q > WC_ONE) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else if (ext_ready) begin
                    state_d    = RUN;
                    core_rdy_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            wcnt_q     <= '0;
            state_q    <= RUN;
            ab_q       <= '0;
            dbo_q      <= '0;
            we_n_q     <= 1'b1;
            bus_stb_q  <= 1'b0;
            core_rdy_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            state_q    <= state_d;
            ab_q       <= ab_d;
            dbo_q      <= dbo_d;
            we_n_q     <= we_n_d;
            bus_stb_q  <= bus_stb_d;
            core_rdy_q <= core_rdy_d;
        end
    end

    assign ab       = ab_q;
    assign dbo      = dbo_q;
    assign we_n     = we_n_q;
    assign bus_stb  = bus_stb_q;
    assign core_rdy = core_rdy_q;

    sync_chain #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_n_in),
        .q     (irq_n)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .reset (reset),
        .d     (nmi_n_in),
        .q     (nmi_n)
    );

endmodule

// File: tb/tb_cpu_bus_stage.sv
// Self-checking bench for cpu_bus_stage with default parameters.
module tb_cpu_bus_stage;

    localparam int          AW          = 16;
    localparam int          DW          = 8;
    localparam int          CE_DIV      = 4;
    localparam logic [15:0] WAIT_BASE   = 16'h8000;
    localparam logic [15:0] WAIT_MASK   = 16'hC000;
    localparam int          WAIT_CYCLES = 2;
    localparam int          SYNC_STAGES = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] core_ab = '0;
    logic [DW-1:0] core_dbo = '0;
    logic          core_we = 1'b0;
    logic          core_ce;
    logic          core_rdy;
    logic [AW-1:0] ab;
    logic [DW-1:0] dbo;
    logic          we_n;
    logic          bus_stb;
    logic          ext_ready = 1'b1;
    logic          irq_n_in = 1'b1;
    logic          nmi_n_in = 1'b1;
    logic          irq_n;
    logic          nmi_n;

    int n_assert = 0;
    int n_fail   = 0;
    int n_since  = 0;   // clk edges since reset was last sampled high

    cpu_bus_stage #(
        .AW          (AW),
        .DW          (DW),
        .CE_DIV      (CE_DIV),
        .WAIT_BASE   (WAIT_BASE),
        .WAIT_MASK   (WAIT_MASK),
        .WAIT_CYCLES (WAIT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_ab   (core_ab),
        .core_dbo  (core_dbo),
        .core_we   (core_we),
        .core_ce   (core_ce),
        .core_rdy  (core_rdy),
        .ab        (ab),
        .dbo       (dbo),
        .we_n      (we_n),
        .bus_stb   (bus_stb),
        .ext_ready (ext_ready),
        .irq_n_in  (irq_n_in),
        .nmi_n_in  (nmi_n_in),
        .irq_n     (irq_n),
        .nmi_n     (nmi_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enable is expected in the last clk of every CE_DIV-clk period after release.
    function automatic logic model_ce();
        return (n_since % CE_DIV) == (CE_DIV - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        n_since = reset ? 0 : n_since + 1;
        #1;
        chk("core_ce", {31'd0, core_ce}, {31'd0, model_ce()});
    endtask

    task automatic wait_ce();
        for (int i = 0; i < CE_DIV && !model_ce(); i++) step();
    endtask

    function automatic logic in_win(input logic [15:0] a);
        return WAIT_CYCLES > 0 && ((a & WAIT_MASK) == (WAIT_BASE & WAIT_MASK));
    endfunction

    // One core access; stall = extra ext_ready-low samples at the end of a window access,
    // rdy = ext_ready level presented at launch for non-window accesses.
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic w,
                          input int stall, input logic rdy);
        int total;
        wait_ce();
        core_ab   = a;
        core_dbo  = d;
        core_we   = w;
        ext_ready = rdy;
        step();
        chk("launch_ab",  {16'd0, ab},   {16'd0, a});
        chk("launch_dbo", {24'd0, dbo},  {24'd0, d});
        chk("launch_we_n", {31'd0, we_n}, {31'd0, ~w});
        chk("launch_stb", {31'd0, bus_stb}, 32'd1);
        if (in_win(a)) begin
            chk("win_rdy_low", {31'd0, core_rdy}, 32'd0);
            total = WAIT_CYCLES + stall;
            if (CE_DIV > 1) begin
                step();
                chk("stb_one_clk", {31'd0, bus_stb}, 32'd0);
            end
            for (int k = 1; k <= total; k++) begin
                wait_ce();
                if (k < WAIT_CYCLES) ext_ready = 1'($urandom_range(1));
                else                 ext_ready = (k == total);
                core_ab  = 16'($urandom);
                core_dbo = 8'($urandom);
                step();
                chk("wait_rdy",  {31'd0, core_rdy}, {31'd0, (k == total)});
                chk("wait_stb",  {31'd0, bus_stb}, 32'd0);
                chk("wait_ab",   {16'd0, ab}, {16'd0, a});
            end
        end else begin
            chk("run_rdy", {31'd0, core_rdy}, {31'd0, rdy});
            if (CE_DIV > 1) begin
                step();
                chk("stb_one_clk", {31'd0, bus_stb}, 32'd0);
                chk("hold_ab",     {16'd0, ab}, {16'd0, a});
            end
        end
        ext_ready = 1'b1;
    endtask

    initial begin
        logic [15:0] a;

        // Reset values
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_ab",    {16'd0, ab}, 32'd0);
        chk("rst_dbo",   {24'd0, dbo}, 32'd0);
        chk("rst_we_n",  {31'd0, we_n}, 32'd1);
        chk("rst_stb",   {31'd0, bus_stb}, 32'd0);
        chk("rst_rdy",   {31'd0, core_rdy}, 32'd1);
        chk("rst_irq_n", {31'd0, irq_n}, 32'd1);
        chk("rst_nmi_n", {31'd0, nmi_n}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Directed accesses
        access(16'h1234, 8'hA5, 1'b1, 0, 1'b1);
        access(16'h0042, 8'h00, 1'b0, 0, 1'b0);
        access(16'h8010, 8'h3C, 1'b0, 0, 1'b1);
        access(16'h8010, 8'h3C, 1'b0, 3, 1'b1);
        access(16'hBFFF, 8'hFF, 1'b1, 1, 1'b1);
        access(16'hC000, 8'h11, 1'b1, 0, 1'b1);

        // Reset mid-WAIT
        wait_ce();
        core_ab = 16'h8010; core_dbo = 8'h77; core_we = 1'b1;
        step();
        chk("pre_rst_rdy", {31'd0, core_rdy}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("midrst_rdy",  {31'd0, core_rdy}, 32'd1);
        chk("midrst_we_n", {31'd0, we_n}, 32'd1);
        chk("midrst_ab",   {16'd0, ab}, 32'd0);
        chk("midrst_stb",  {31'd0, bus_stb}, 32'd0);
        reset = 1'b0;
        core_ab = 16'h0000; core_we = 1'b0;
        for (int i = 0; i < 12; i++) step();
        access(16'h2222, 8'h5A, 1'b1, 0, 1'b1);

        // Randomised accesses
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            if ($urandom_range(1) == 1) a = (WAIT_BASE & WAIT_MASK) | (a & ~WAIT_MASK);
            access(a, 8'($urandom), 1'($urandom_range(1)), int'($urandom_range(2)),
                   1'($urandom_range(1)));
        end

        // Interrupt synchronisers
        step();
        #2 nmi_n_in = 1'b0;
        for (int s = 1; s <= SYNC_STAGES; s++) begin
            step();
            chk("nmi_sync", {31'd0, nmi_n}, {31'd0, (s < SYNC_STAGES)});
            chk("irq_quiet", {31'd0, irq_n}, 32'd1);
        end
        #3 irq_n_in = 1'b0;
        nmi_n_in = 1'b1;
        for (int s = 1; s <= SYNC_STAGES; s++) begin
            step();
            chk("irq_sync", {31'd0, irq_n}, {31'd0, (s < SYNC_STAGES)});
            chk("nmi_rise", {31'd0, nmi_n}, {31'd0, (s == SYNC_STAGES)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
